pc_fetch_ctrl: RTL and testbench

Fetch sequencer that owns the program counter and drives instruction-memory fetches for the single-issue core. It chooses the next PC from four sources: sequential, branch/jump redirect, trap vector, or hold. It issues one outstanding request at a time on a valid/ready memory port, and presents fetched instructions to decode through a one-entry output register with valid/ready backpressure. It sits between the instruction memory and the IF/ID boundary, and replaces free-running PC update with sequenced, stall-aware control.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/pc_next_sel.sv | 30 +++
 rtl/pc_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Included by the next-PC mux and the fetch controller top.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0080;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: trap beats redirect beats sequential advance, otherwise hold.
// Redirect targets are forced to word alignment; arithmetic wraps modulo 2^32.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        trap_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_next_o,
  output logic        flush_o
);

  always_comb begin
    pc_next_o = pc_i;
    if (trap_i) begin
      pc_next_o = TRAP_VEC;
    end else if (redirect_valid_i) begin
      pc_next_o = align_word(redirect_pc_i);
    end else if (advance_i) begin
      pc_next_o = pc_i + INSTR_BYTES;
    end
  end

  assign flush_o = trap_i | redirect_valid_i;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one outstanding instruction fetch at a time
// and hands fetched words to decode through a one-entry output register.
module pc_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap,
  input  logic        halt
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  req_addr_q;
  logic         req_valid_q;
  logic         drop_q;
  logic         if_valid_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  buf_instr_q;
  logic [31:0]  buf_pc_q;

  logic flush;
  logic rsp_take;
  logic rsp_good;
  logic out_free;
  logic out_drain;

  assign rsp_take  = (state_q == S_WAIT) && imem_rsp_valid;
  assign rsp_good  = rsp_take && !drop_q && !flush;
  assign out_drain = if_valid_q && id_ready;
  assign out_free  = !if_valid_q || id_ready;

  pc_next_sel #(
    .TRAP_VEC(TRAP_VEC)
  ) u_pc_next_sel (
    .trap_i          (trap),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .pc_i            (pc_q),
    .advance_i       (rsp_good),
    .pc_next_o       (pc_d),
    .flush_o         (flush)
  );

  // req_addr_q only moves when entering REQ, so a stalled request keeps its
  // address; a redirect seen meanwhile lands in pc_q and marks the request stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP_INSTR;
      if_pc_q     <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      if (out_drain || flush) begin
        if_valid_q <= 1'b0;
      end
      case (state_q)
        S_BOOT: begin
          state_q     <= halt ? S_BOOT : S_REQ;
          req_valid_q <= !halt;
          req_addr_q  <= pc_d;
        end
        S_REQ: begin
          drop_q <= drop_q | flush;
          if (imem_req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rsp_take) begin
            drop_q <= 1'b0;
            if (!rsp_good || out_free) begin
              if (rsp_good) begin
                if_valid_q <= 1'b1;
                if_instr_q <= imem_rsp_data;
                if_pc_q    <= req_addr_q;
              end
              state_q     <= halt ? S_BOOT : S_REQ;
              req_valid_q <= !halt;
              req_addr_q  <= pc_d;
            end else begin
              buf_instr_q <= imem_rsp_data;
              buf_pc_q    <= req_addr_q;
              state_q     <= S_FULL;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (flush || out_drain) begin
            if (!flush) begin
              if_valid_q <= 1'b1;
              if_instr_q <= buf_instr_q;
              if_pc_q    <= buf_pc_q;
            end
            state_q     <= halt ? S_BOOT : S_REQ;
            req_valid_q <= !halt;
            req_addr_q  <= pc_d;
          end
        end
        default: begin
          state_q     <= S_BOOT;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expected values.
module tb_pc_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] TVEC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap;
  logic        halt;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mem_lat;
  bit          force_rsp;
  logic [31:0] req_log[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .trap          (trap),
    .halt          (halt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Instruction memory: answers each accepted request mem_lat cycles later.
  initial begin : imem
    logic        mp_pend;
    int          mp_cnt;
    logic [31:0] mp_addr;
    bit          rv;
    mp_pend = 1'b0;
    mp_cnt = 0;
    mp_addr = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) mp_pend = 1'b0;
      else if (imem_req_valid && imem_req_ready) begin
        mp_pend = 1'b1;
        mp_cnt = mem_lat;
        mp_addr = imem_req_addr;
      end
      @(posedge clk);
      #2;
      rv = 1'b0;
      if (mp_pend && rst_n) begin
        mp_cnt--;
        if (mp_cnt == 0) begin
          rv = 1'b1;
          mp_pend = 1'b0;
        end
      end
      imem_rsp_valid = rv | force_rsp;
      imem_rsp_data = force_rsp ? 32'hDEAD_BEEF : mem_word(mp_addr);
    end
  end

  // Behavioural model: program order, request legality and delivery latency.
  initial begin : monitor
    bit          have_prev, outstanding, out_stale, stale_pend, exp_del;
    bit          p_valid, p_ready, p_halt, p_flush;
    bit          hs, redir;
    logic [31:0] p_addr, fetch_pc, dec_pc, out_addr, del_addr, tgt;
    have_prev = 0; outstanding = 0; out_stale = 0; stale_pend = 0; exp_del = 0;
    p_valid = 0; p_ready = 0; p_halt = 0; p_flush = 0;
    p_addr = 0; fetch_pc = 0; dec_pc = 0; out_addr = 0; del_addr = 0; tgt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, NOP_INSTR);
        chk("rst_if_pc", if_pc, 32'h0);
        have_prev = 0; outstanding = 0; stale_pend = 0; exp_del = 0;
        fetch_pc = 32'h0; dec_pc = 32'h0;
      end else begin
        if (have_prev) begin
          if (p_valid && !p_ready) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_req_addr, p_addr);
          end
          if (!p_valid && p_halt) chk("halt_no_new_req", imem_req_valid, 0);
          if (p_flush) chk("flush_if_valid", if_valid, 0);
          if (exp_del) begin
            chk("rsp_to_if_valid", if_valid, 1);
            chk("rsp_to_if_pc", if_pc, del_addr);
          end
        end
        if (if_valid) chk("if_instr_data", if_instr, mem_word(if_pc));

        hs = imem_req_valid && imem_req_ready;
        redir = trap || redirect_valid;
        exp_del = 0;
        if (if_valid && id_ready) begin
          chk("consume_pc_order", if_pc, dec_pc);
          dec_pc += 32'd4;
        end
        if (imem_rsp_valid && outstanding) begin
          outstanding = 0;
          if (!out_stale && !redir && (!if_valid || id_ready)) begin
            exp_del = 1;
            del_addr = out_addr;
          end
        end
        if (hs) begin
          chk("one_outstanding", outstanding, 0);
          if (stale_pend) begin
            out_stale = 1;
            stale_pend = 0;
          end else begin
            chk("req_addr_seq", imem_req_addr, fetch_pc);
            fetch_pc += 32'd4;
            out_stale = 0;
          end
          outstanding = 1;
          out_addr = imem_req_addr;
          req_log.push_back(imem_req_addr);
        end
        if (redir) begin
          tgt = trap ? TVEC : {redirect_pc[31:2], 2'b00};
          fetch_pc = tgt;
          dec_pc = tgt;
          if (outstanding) out_stale = 1;
          if (imem_req_valid && !imem_req_ready) stale_pend = 1;
        end
        p_valid = imem_req_valid; p_ready = imem_req_ready; p_addr = imem_req_addr;
        p_halt = halt; p_flush = redir;
        have_prev = 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    rst_n = 1'b0;
    redirect_valid = 1'b0; trap = 1'b0; halt = 1'b0;
    id_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = lat;
    step(2);
    req_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_if_valid(input string name, input int maxc);
    int c = 0;
    while (!if_valid && c < maxc) begin
      step(1);
      c++;
    end
    chk(name, if_valid, 1);
  endtask

  task automatic wait_req_count(input int n, input int maxc);
    int c = 0;
    while (req_log.size() < n && c < maxc) begin
      step(1);
      c++;
    end
    chk("req_count_reached", req_log.size(), n);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    imem_req_ready = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    trap = 1'b0; halt = 1'b0; mem_lat = 1; force_rsp = 1'b0;
    #1;

    // Sequential fetch after reset
    do_reset(1);
    step(1);
    chk("t1_first_req_valid", imem_req_valid, 1);
    chk("t1_first_req_addr", imem_req_addr, 32'h0);
    step(2);
    chk("t1_if_valid", if_valid, 1);
    chk("t1_if_pc", if_pc, 32'h0);
    chk("t1_if_instr", if_instr, 32'h1357_9BDF);
    chk("t1_next_req_addr", imem_req_addr, 32'h4);
    wait_req_count(3, 20);
    chk("t1_req0", req_log[0], 32'h0);
    chk("t1_req1", req_log[1], 32'h4);
    chk("t1_req2", req_log[2], 32'h8);
    step(4);

    // Decode backpressure: one buffered response, no third request
    do_reset(1);
    step(3);
    id_ready = 1'b0;
    step(5);
    chk("t2_held_valid", if_valid, 1);
    chk("t2_held_pc", if_pc, 32'h0);
    chk("t2_held_instr", if_instr, 32'h1357_9BDF);
    chk("t2_no_third_req", imem_req_valid, 0);
    chk("t2_req_count", req_log.size(), 2);
    id_ready = 1'b1;
    step(1);
    chk("t2_buffered_valid", if_valid, 1);
    chk("t2_buffered_pc", if_pc, 32'h4);
    chk("t2_buffered_instr", if_instr, 32'h1357_9BDB);
    step(4);

    // Redirect while a slow fetch is in flight
    do_reset(3);
    step(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
    step(1);
    redirect_valid = 1'b0;
    chk("t3_flush_valid", if_valid, 0);
    step(2);
    chk("t3_redir_req_valid", imem_req_valid, 1);
    chk("t3_redir_req_addr", imem_req_addr, 32'h0000_1000);
    chk("t3_no_instr_yet", if_valid, 0);
    wait_if_valid("t3_new_instr_arrives", 10);
    chk("t3_new_pc", if_pc, 32'h0000_1000);
    chk("t3_new_instr", if_instr, 32'h1357_8BDF);
    step(3);

    // Trap and redirect together: trap wins
    do_reset(1);
    trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    step(1);
    trap = 1'b0; redirect_valid = 1'b0;
    chk("t4_trap_req_valid", imem_req_valid, 1);
    chk("t4_trap_req_addr", imem_req_addr, 32'h0000_0080);
    wait_if_valid("t4_trap_instr", 10);
    chk("t4_trap_if_pc", if_pc, 32'h0000_0080);
    step(3);

    // PC wrap at the top of the address space
    do_reset(1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step(1);
    redirect_valid = 1'b0;
    chk("t5_req_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    step(2);
    chk("t5_wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("t5_wrap_next_req", imem_req_addr, 32'h0);
    step(3);

    // Reset during WAIT, then a stray late response
    do_reset(3);
    step(2);
    rst_n = 1'b0; mem_lat = 1;
    #1;
    chk("t6_rst_req_valid", imem_req_valid, 0);
    chk("t6_rst_if_valid", if_valid, 0);
    chk("t6_rst_if_instr", if_instr, 32'h0000_0013);
    step(1);
    rst_n = 1'b1; force_rsp = 1'b1;
    step(1);
    chk("t6_first_req_valid", imem_req_valid, 1);
    chk("t6_first_req_addr", imem_req_addr, 32'h0);
    step(1);
    force_rsp = 1'b0;
    step(1);
    chk("t6_if_valid", if_valid, 1);
    chk("t6_if_pc", if_pc, 32'h0);
    chk("t6_if_instr", if_instr, 32'h1357_9BDF);
    step(3);

    // Halt, stalled request, redirect while the request is stalled
    do_reset(1);
    halt = 1'b1;
    step(3);
    chk("t7_halt_no_req", imem_req_valid, 0);
    halt = 1'b0; imem_req_ready = 1'b0;
    step(1);
    chk("t7_resume_req_valid", imem_req_valid, 1);
    chk("t7_resume_req_addr", imem_req_addr, 32'h0);
    step(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    step(1);
    redirect_valid = 1'b0;
    chk("t7_stall_valid", imem_req_valid, 1);
    chk("t7_stall_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    wait_if_valid("t7_redir_instr", 12);
    chk("t7_redir_if_pc", if_pc, 32'h0000_3000);
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
